key_debouncer: RTL

Conditions the raw board push-buttons before they drive lab logic such as the mux exercises' sel/a/b inputs. Per key, it synchronizes the asynchronous input, rejects bounce with a saturating-count filter, and produces:
- a clean level
- one-cycle press and release pulses
- a press-toggled latch

All keys are processed independently in parallel and share no state.

---
 rtl/key_debouncer.sv | 64 ++++++
 1 files changed

// File: rtl/key_debouncer.sv
// key_debouncer: per-key synchronizer, saturating-count bounce filter, edge pulses and press toggle
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   key_raw      raw button pins, asynchronous to clk
//   key_level    debounced pressed state, 1 = pressed
//   key_press    one-cycle pulse when key_level rises
//   key_release  one-cycle pulse when key_level falls
//   key_toggle   inverts on every press pulse
//   any_press    OR of key_press, registered alongside it
module key_debouncer #(
  parameter int clk_mhz = 50,
  parameter int w_key = 4,
  parameter int debounce_us = 10000,
  parameter int debounce_cycles = clk_mhz * debounce_us,
  parameter int key_active_low = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [w_key-1:0] key_raw,
  output logic [w_key-1:0] key_level,
  output logic [w_key-1:0] key_press,
  output logic [w_key-1:0] key_release,
  output logic [w_key-1:0] key_toggle,
  output logic             any_press
);
  localparam int cw = $clog2(debounce_cycles + 1);
  if (debounce_cycles < 1) begin : g_bad
    $error("debounce_cycles must be at least 1");
  end
  logic [w_key-1:0] s1, s2, hit, rise;
  logic [cw-1:0] cnt [w_key];
  // hit: a mismatch run has lasted long enough to be accepted on this edge
  always_comb begin
    hit = '0;
    for (int i = 0; i < w_key; i++)
      hit[i] = (s2[i] != key_level[i]) && (cnt[i] == cw'(debounce_cycles - 1));
    rise = hit & s2;
  end
  // key_level is the filter's stable bit itself, so it is registered by construction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      key_level <= '0;
      key_press <= '0;
      key_release <= '0;
      key_toggle <= '0;
      any_press <= 1'b0;
      for (int i = 0; i < w_key; i++) cnt[i] <= '0;
    end else begin
      s1 <= key_raw ^ {w_key{key_active_low != 0}};
      s2 <= s1;
      key_level <= key_level ^ hit;
      key_press <= rise;
      key_release <= hit & ~s2;
      key_toggle <= key_toggle ^ rise;
      any_press <= |rise;
      // any return to the stable value restarts the run from zero
      for (int i = 0; i < w_key; i++)
        cnt[i] <= (s2[i] == key_level[i] || hit[i]) ? '0 : cnt[i] + cw'(1);
    end
  end
endmodule
